// File: rtl/rom_stream_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rom_stream_loader
//
// Parses framed load packets arriving as a byte stream and turns them into
// single-cycle 16-bit word writes on the game ROM/RAM write port (port B).
// While a frame is in flight the 68k is held in reset through cpu_hold.
//
// Frame (all fields MSB first):
//   SYNC, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, {DATA_HI, DATA_LO} x LEN, CHK
//   CHK is the XOR of every data byte.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   rx_valid  one-cycle strobe qualifying rx_data
//   rx_data   received byte
//   we_b      ROM write strobe, one cycle per word
//   addr_b    ROM word address (ROM addr[14:1])
//   din_b     ROM write data
//   loading   high from SYNC until the frame ends (good, bad or timed out)
//   cpu_hold  CPU reset request, mirrors loading
//   done      sticky: last frame completed with a good checksum
//   error     sticky: last frame had bad length, bad checksum or timed out
// -----------------------------------------------------------------------------
module rom_stream_loader #(
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter int          ADDR_W  = 14,
  parameter logic [23:0] TIMEOUT = 24'd2_500_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              we_b,
  output logic [ADDR_W-1:0] addr_b,
  output logic [15:0]       din_b,
  output logic              loading,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [15:0]       MAX_LEN = 16'd16384;
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_H,
    S_ADDR_L,
    S_LEN_H,
    S_LEN_L,
    S_DATA_H,
    S_DATA_L,
    S_CHECK
  } state_t;

  state_t              state_q;
  logic [ADDR_W-9:0]   addr_hi_q;   // only the address bits that survive truncation
  logic [ADDR_W-1:0]   ptr_q;
  logic [7:0]          len_hi_q;
  logic [14:0]         cnt_q;       // words remaining, 0..16384
  logic [7:0]          chk_q;
  logic [23:0]         to_cnt_q;
  logic                we_q;
  logic [15:0]         din_q;
  logic                loading_q;
  logic                done_q;
  logic                error_q;

  logic [15:0]         len_d;
  logic                timeout_d;

  assign len_d = {len_hi_q, rx_data};

  // Fires on the cycle the silence counter would reach TIMEOUT; a byte
  // arriving in that same cycle still wins.
  assign timeout_d = (state_q != S_IDLE) && !rx_valid &&
                     (to_cnt_q == TIMEOUT - 24'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_hi_q <= '0;
      ptr_q     <= '0;
      len_hi_q  <= '0;
      cnt_q     <= '0;
      chk_q     <= '0;
      to_cnt_q  <= '0;
      we_q      <= 1'b0;
      din_q     <= '0;
      loading_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;

      // The write presents the old pointer; advance it once the strobe is out.
      if (we_q) begin
        ptr_q <= ptr_q + PTR_ONE;
      end

      if ((state_q == S_IDLE) || rx_valid) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + 24'd1;
      end

      if (timeout_d) begin
        error_q   <= 1'b1;
        loading_q <= 1'b0;
        state_q   <= S_IDLE;
        to_cnt_q  <= '0;
      end else if (rx_valid) begin
        case (state_q)
          S_IDLE: begin
            if (rx_data == SYNC) begin
              state_q   <= S_ADDR_H;
              loading_q <= 1'b1;
              done_q    <= 1'b0;
              error_q   <= 1'b0;
            end
          end
          S_ADDR_H: begin
            addr_hi_q <= rx_data[ADDR_W-9:0];
            state_q   <= S_ADDR_L;
          end
          S_ADDR_L: begin
            ptr_q   <= {addr_hi_q, rx_data};
            state_q <= S_LEN_H;
          end
          S_LEN_H: begin
            len_hi_q <= rx_data;
            chk_q    <= '0;
            state_q  <= S_LEN_L;
          end
          S_LEN_L: begin
            chk_q <= '0;
            if (len_d > MAX_LEN) begin
              error_q   <= 1'b1;
              loading_q <= 1'b0;
              state_q   <= S_IDLE;
            end else if (len_d == 16'd0) begin
              state_q <= S_CHECK;
            end else begin
              cnt_q   <= len_d[14:0];
              state_q <= S_DATA_H;
            end
          end
          S_DATA_H: begin
            din_q[15:8] <= rx_data;
            chk_q       <= chk_q ^ rx_data;
            state_q     <= S_DATA_L;
          end
          S_DATA_L: begin
            din_q[7:0] <= rx_data;
            chk_q      <= chk_q ^ rx_data;
            we_q       <= 1'b1;
            cnt_q      <= cnt_q - 15'd1;
            if (cnt_q == 15'd1) begin
              state_q <= S_CHECK;
            end else begin
              state_q <= S_DATA_H;
            end
          end
          S_CHECK: begin
            if (rx_data == chk_q) begin
              done_q <= 1'b1;
            end else begin
              error_q <= 1'b1;
            end
            loading_q <= 1'b0;
            state_q   <= S_IDLE;
          end
          default: begin
            loading_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign we_b     = we_q;
  assign addr_b   = ptr_q;
  assign din_b    = din_q;
  assign loading  = loading_q;
  assign cpu_hold = loading_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_rom_stream_loader.sv
`timescale 1ns/1ps
module tb_rom_stream_loader;

  localparam int TMO = 100;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        we_b;
  logic [13:0] addr_b;
  logic [15:0] din_b;
  logic        loading;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int vec_cnt = 0;
  int err_cnt = 0;

  int cyc = 0;
  int last_rx_cyc = 0;
  int width_err = 0;
  logic prev_we = 1'b0;
  logic [13:0] wr_addr[$];
  logic [15:0] wr_data[$];
  int          wr_lat[$];
  byte_q_t     frame;

  always #5 clk = ~clk;

  rom_stream_loader #(
    .SYNC(8'hA5),
    .ADDR_W(14),
    .TIMEOUT(24'(TMO))
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .we_b(we_b),
    .addr_b(addr_b),
    .din_b(din_b),
    .loading(loading),
    .cpu_hold(cpu_hold),
    .done(done),
    .error(error)
  );

  always @(posedge clk) begin
    if (rx_valid) last_rx_cyc = cyc;
    cyc = cyc + 1;
  end

  // Write monitor: logs every write strobe, its latency from the last byte
  // and any strobe longer than one cycle.
  always @(negedge clk) begin
    if (we_b === 1'b1) begin
      wr_addr.push_back(addr_b);
      wr_data.push_back(din_b);
      wr_lat.push_back(cyc - last_rx_cyc);
      $display("write addr=%h data=%h latency=%0d", addr_b, din_b, cyc - last_rx_cyc);
      if (prev_we === 1'b1) width_err++;
    end
    prev_we = we_b;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_lat.delete();
    width_err = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input byte_q_t bytes);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    vec_cnt++;
    if ({we_b, addr_b, din_b} !== 31'd0) begin
      err_cnt++;
      $display("FAIL reset_port: got we=%b addr=%h din=%h want 0/0000/0000", we_b, addr_b, din_b);
    end
    vec_cnt++;
    if ({loading, cpu_hold, done, error} !== 4'b0000) begin
      err_cnt++;
      $display("FAIL reset_status: got %b want 0000", {loading, cpu_hold, done, error});
    end
    reset = 1'b0;
    idle(2);
    $display("frame reset: done");
  endtask

  task automatic test_directed_load();
    clear_log();
    frame = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02};
    send_frame(frame);
    vec_cnt++;
    if ({loading, cpu_hold} !== 2'b11) begin
      err_cnt++;
      $display("FAIL load_hold: got %b want 11", {loading, cpu_hold});
    end
    frame = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    send_frame(frame);
    idle(4);
    vec_cnt++;
    if (wr_addr.size() !== 2) begin
      err_cnt++;
      $display("FAIL load_count: got %0d want 2", wr_addr.size());
    end
    if (wr_addr.size() == 2) begin
      vec_cnt++;
      if (wr_addr[0] !== 14'h0010 || wr_data[0] !== 16'h1234) begin
        err_cnt++;
        $display("FAIL load_w0: got %h/%h want 0010/1234", wr_addr[0], wr_data[0]);
      end
      vec_cnt++;
      if (wr_addr[1] !== 14'h0011 || wr_data[1] !== 16'h5678) begin
        err_cnt++;
        $display("FAIL load_w1: got %h/%h want 0011/5678", wr_addr[1], wr_data[1]);
      end
      vec_cnt++;
      if (wr_lat[0] !== 1 || wr_lat[1] !== 1) begin
        err_cnt++;
        $display("FAIL load_latency: got %0d,%0d want 1,1", wr_lat[0], wr_lat[1]);
      end
    end
    vec_cnt++;
    if (width_err !== 0) begin
      err_cnt++;
      $display("FAIL load_width: got %0d long strobes want 0", width_err);
    end
    vec_cnt++;
    if ({done, error, loading, cpu_hold} !== 4'b1000) begin
      err_cnt++;
      $display("FAIL load_status: got %b want 1000", {done, error, loading, cpu_hold});
    end
    vec_cnt++;
    if (addr_b !== 14'h0012) begin
      err_cnt++;
      $display("FAIL load_ptr_after: got %h want 0012", addr_b);
    end
    $display("frame directed_load: writes=%0d", wr_addr.size());
  endtask

  task automatic test_bad_checksum();
    clear_log();
    frame = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
    send_frame(frame);
    idle(4);
    vec_cnt++;
    if (wr_addr.size() !== 2) begin
      err_cnt++;
      $display("FAIL badchk_count: got %0d want 2", wr_addr.size());
    end
    vec_cnt++;
    if ({done, error, loading} !== 3'b010) begin
      err_cnt++;
      $display("FAIL badchk_status: got %b want 010", {done, error, loading});
    end
    $display("frame bad_checksum: writes=%0d", wr_addr.size());
  endtask

  task automatic test_zero_and_oversize();
    clear_log();
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(frame);
    idle(4);
    vec_cnt++;
    if (wr_addr.size() !== 0 || {done, error, loading} !== 3'b100) begin
      err_cnt++;
      $display("FAIL zero_len: got writes=%0d status=%b want 0/100", wr_addr.size(), {done, error, loading});
    end
    $display("frame zero_length: writes=%0d", wr_addr.size());

    clear_log();
    frame = '{8'hA5, 8'h00, 8'h00, 8'h40, 8'h01};
    send_frame(frame);
    idle(2);
    vec_cnt++;
    if (wr_addr.size() !== 0 || {done, error, loading} !== 3'b010) begin
      err_cnt++;
      $display("FAIL oversize: got writes=%0d status=%b want 0/010", wr_addr.size(), {done, error, loading});
    end
    send_byte(8'hA5);
    vec_cnt++;
    if ({loading, error} !== 2'b10) begin
      err_cnt++;
      $display("FAIL oversize_resync: got %b want 10", {loading, error});
    end
    frame = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(frame);
    idle(3);
    vec_cnt++;
    if ({done, error, loading} !== 3'b100) begin
      err_cnt++;
      $display("FAIL oversize_next: got %b want 100", {done, error, loading});
    end
    $display("frame oversize: writes=%0d", wr_addr.size());
  endtask

  task automatic test_wrap();
    clear_log();
    frame = '{8'hA5, 8'h3F, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    send_frame(frame);
    idle(4);
    vec_cnt++;
    if (wr_addr.size() !== 2) begin
      err_cnt++;
      $display("FAIL wrap_count: got %0d want 2", wr_addr.size());
    end
    if (wr_addr.size() == 2) begin
      vec_cnt++;
      if (wr_addr[0] !== 14'h3FFF || wr_data[0] !== 16'hAABB) begin
        err_cnt++;
        $display("FAIL wrap_w0: got %h/%h want 3fff/aabb", wr_addr[0], wr_data[0]);
      end
      vec_cnt++;
      if (wr_addr[1] !== 14'h0000 || wr_data[1] !== 16'hCCDD) begin
        err_cnt++;
        $display("FAIL wrap_w1: got %h/%h want 0000/ccdd", wr_addr[1], wr_data[1]);
      end
    end
    vec_cnt++;
    if ({done, error} !== 2'b10) begin
      err_cnt++;
      $display("FAIL wrap_status: got %b want 10", {done, error});
    end
    $display("frame wrap: writes=%0d", wr_addr.size());
  endtask

  task automatic test_timeout();
    clear_log();
    frame = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h01, 8'h11};
    send_frame(frame);
    idle(TMO / 2);
    vec_cnt++;
    if ({loading, error} !== 2'b10) begin
      err_cnt++;
      $display("FAIL timeout_early: got %b want 10", {loading, error});
    end
    idle(TMO / 2 + 10);
    vec_cnt++;
    if ({loading, cpu_hold, error, done} !== 4'b0010 || wr_addr.size() !== 0) begin
      err_cnt++;
      $display("FAIL timeout_fire: got status=%b writes=%0d want 0010/0", {loading, cpu_hold, error, done}, wr_addr.size());
    end
    $display("frame timeout: writes=%0d", wr_addr.size());

    clear_log();
    frame = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33};
    send_frame(frame);
    idle(4);
    vec_cnt++;
    if (wr_addr.size() !== 1) begin
      err_cnt++;
      $display("FAIL timeout_next_count: got %0d want 1", wr_addr.size());
    end else begin
      vec_cnt++;
      if (wr_addr[0] !== 14'h0020 || wr_data[0] !== 16'h1122) begin
        err_cnt++;
        $display("FAIL timeout_next_w0: got %h/%h want 0020/1122", wr_addr[0], wr_data[0]);
      end
    end
    vec_cnt++;
    if ({done, error} !== 2'b10) begin
      err_cnt++;
      $display("FAIL timeout_next_status: got %b want 10", {done, error});
    end
    $display("frame after_timeout: writes=%0d", wr_addr.size());
  endtask

  task automatic test_reset_mid_frame();
    clear_log();
    frame = '{8'hA5, 8'h00, 8'h30, 8'h00, 8'h01, 8'h12};
    send_frame(frame);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h34;
    reset    = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    vec_cnt++;
    if ({we_b, addr_b, din_b, loading, cpu_hold, done, error} !== 35'd0) begin
      err_cnt++;
      $display("FAIL midreset_outputs: got we=%b addr=%h din=%h st=%b want all 0",
               we_b, addr_b, din_b, {loading, cpu_hold, done, error});
    end
    @(negedge clk);
    reset = 1'b0;
    idle(3);
    vec_cnt++;
    if (wr_addr.size() !== 0) begin
      err_cnt++;
      $display("FAIL midreset_nowrite: got %0d writes want 0", wr_addr.size());
    end
    send_byte(8'h55);
    vec_cnt++;
    if (loading !== 1'b0) begin
      err_cnt++;
      $display("FAIL garbage_ignored: got loading=%b want 0", loading);
    end
    frame = '{8'hA5, 8'h00, 8'h40, 8'h00, 8'h01, 8'h9A, 8'hBC, 8'h26};
    send_frame(frame);
    idle(4);
    vec_cnt++;
    if (wr_addr.size() !== 1 || {done, error} !== 2'b10) begin
      err_cnt++;
      $display("FAIL midreset_next: got writes=%0d status=%b want 1/10", wr_addr.size(), {done, error});
    end else begin
      vec_cnt++;
      if (wr_addr[0] !== 14'h0040 || wr_data[0] !== 16'h9ABC) begin
        err_cnt++;
        $display("FAIL midreset_next_w0: got %h/%h want 0040/9abc", wr_addr[0], wr_data[0]);
      end
    end
    $display("frame reset_mid_frame: writes=%0d", wr_addr.size());
  endtask

  task automatic test_back_to_back();
    clear_log();
    // SYNC value inside the payload, and address upper bits that must be dropped.
    frame = '{8'hA5, 8'hC0, 8'h50, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'h00,
              8'hA5, 8'h00, 8'h60, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03};
    send_frame(frame);
    idle(4);
    vec_cnt++;
    if (wr_addr.size() !== 2) begin
      err_cnt++;
      $display("FAIL b2b_count: got %0d want 2", wr_addr.size());
    end else begin
      vec_cnt++;
      if (wr_addr[0] !== 14'h0050 || wr_data[0] !== 16'hA5A5) begin
        err_cnt++;
        $display("FAIL b2b_w0: got %h/%h want 0050/a5a5", wr_addr[0], wr_data[0]);
      end
      vec_cnt++;
      if (wr_addr[1] !== 14'h0060 || wr_data[1] !== 16'h0102) begin
        err_cnt++;
        $display("FAIL b2b_w1: got %h/%h want 0060/0102", wr_addr[1], wr_data[1]);
      end
    end
    vec_cnt++;
    if ({done, error, loading} !== 3'b100) begin
      err_cnt++;
      $display("FAIL b2b_status: got %b want 100", {done, error, loading});
    end
    $display("frame back_to_back: writes=%0d", wr_addr.size());
  endtask

  initial begin
    test_reset();
    test_directed_load();
    test_bad_checksum();
    test_zero_and_oversize();
    test_wrap();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/rom_stream_loader.md
Name:
rom_stream_loader

Overview:
- Upstream write-side feeder for the 16K x 16 game ROM/RAM port B.
- Consumes a byte stream from the UART/ESP32 byte receiver and parses a framed load packet.
- Assembles big-endian 16-bit words and issues single-cycle word writes on the ROM's we_b/addr_b/din_b port.
- Holds the 68k in reset while a load is in progress, and reports done or error status.

Parameters:
- SYNC, 8'hA5, frame start byte.
- ADDR_W, 14, word-address width; matches ROM port addr[14:1].
- TIMEOUT, 24'd2_500_000, maximum clk cycles allowed between bytes inside a frame.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_valid  in  1  one-cycle strobe: rx_data is valid
- rx_data  in  8  received byte
- we_b  out  1  ROM write strobe, one cycle per word
- addr_b  out  ADDR_W  ROM word address, bits [14:1]
- din_b  out  16  ROM write data
- loading  out  1  high while a frame is being parsed, SYNC through CHECK
- cpu_hold  out  1  CPU reset request; equals loading
- done  out  1  sticky; set when a frame completes with a good checksum
- error  out  1  sticky; set on bad length, bad checksum or timeout

Behaviour:
- Clock and reset: one clock domain (clk). reset is synchronous and active-high.
- Reset values: state=IDLE; we_b=0, addr_b=0, din_b=0; loading, cpu_hold, done and error all 0; timeout counter=0.
- Frame format, all fields MSB first: SYNC, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, then LEN words (hi byte, lo byte), then CHK.
- ADDR is a 16-bit word address. Only the low ADDR_W bits are used; the upper bits are ignored.
- LEN is a word count. The legal range is 0..16384.
- States: IDLE, ADDR_H, ADDR_L, LEN_H, LEN_L, DATA_H, DATA_L, CHECK.
- State advances only on rx_valid; each transition consumes exactly one byte.
- IDLE: any byte other than SYNC is discarded. SYNC -> ADDR_H, which sets loading=1 and clears done and error.
- ADDR_H / ADDR_L: load the address pointer.
- LEN_H / LEN_L: load the word counter and clear the running checksum.
  - LEN > 16384 -> set error and go to IDLE.
  - LEN == 0 -> go to CHECK.
  - Otherwise -> go to DATA_H.
- DATA_H: latch the high byte into din_b[15:8].
- DATA_L: latch the low byte into din_b[7:0] and assert we_b=1 on the next cycle for exactly one cycle, with addr_b=pointer.
  - The pointer increments the cycle after the write.
  - The pointer wraps modulo 2^ADDR_W (16383 -> 0).
  - Counter decrements. Reaching 0 -> CHECK; otherwise -> DATA_H.
- Latency: the rising edge of we_b falls exactly 1 cycle after the rx_valid of the low byte.
- Checksum: XOR of all data bytes, both hi and lo of every word. In CHECK, the received byte is compared with the checksum.
  - Match -> done=1.
  - Mismatch -> error=1.
  - Either way -> IDLE with loading=0.
- Data already written is never rolled back. error only reports the failure.
- Timeout: the counter runs whenever state != IDLE and clears on every rx_valid. When it reaches TIMEOUT: error=1, go to IDLE, loading=0, no write issued.
- A SYNC byte inside a frame is treated as data, not as a restart.
- rx_valid in the same cycle as we_b is legal. Bytes arrive at most one per 2 cycles.
- Reset mid-frame: any pending write is dropped, we_b=0 immediately, and all outputs return to their reset values.

Test Plan:
- Directed load: frame A5 00 10 00 02 12 34 56 78 08 -> two writes: addr 0x0010 / 0x1234, then addr 0x0011 / 0x5678. Each we_b is 1 cycle wide. Afterwards done=1, error=0, loading=0.
- Bad checksum: same frame with CHK=0x00 -> both writes occur, error=1, done=0, state IDLE.
- Zero length and oversize: A5 00 00 00 00 00 -> done=1 with no we_b. A5 00 00 40 01 -> error=1 after LEN_LO with no writes, then the next SYNC is accepted.
- Wrap: ADDR=0x3FFF, LEN=2 -> writes land at 0x3FFF then 0x0000.
- Timeout: stop sending after DATA_H, wait TIMEOUT cycles -> error=1, loading=0, no partial write. A following good frame loads correctly and clears error.
- Reset mid-frame: assert reset during DATA_L -> no we_b pulse, all outputs 0. A garbage byte before SYNC is ignored.
